time_unit_counter: RTL
======================

TIME_UNIT_COUNTER -- requirements
Module: time_unit_counter

Interface
REQ-001 SHALL provide parameter MODULUS, default 60: count range 0..MODULUS-1.
REQ-002 SHALL provide parameter WIDTH, default 6: width of count, load and lap values.
REQ-003 SHALL provide port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL provide port mode, input, 3: operating mode, encoded per REQ-012.
REQ-006 SHALL provide port tick_in, input, 1: count enable from a prescaler or the previous cascade stage.
REQ-007 SHALL provide port load_val, input, WIDTH: preset value used in LOAD mode.
REQ-008 SHALL provide port lap_req, input, 1: request to snapshot the current count.
REQ-009 SHALL provide port count, output, WIDTH: registered current count.
REQ-010 SHALL provide port tick_out, output, 1: combinational carry/borrow to the next cascade stage.
REQ-011 SHALL provide ports lap_val (output, WIDTH), lap_valid (output, 1) and load_err (output, 1): snapshot value, snapshot strobe and load-error flag.

Function
REQ-012 Mode encodings SHALL be: 000 CLEAR, 001 HOLD, 010 UP, 011 DOWN, 100 LOAD; 101-111 behave as HOLD.
REQ-013 CLEAR: count SHALL become 0 on the next edge, regardless of tick_in.
REQ-014 HOLD: count SHALL keep its value.
REQ-015 UP with tick_in=1: count SHALL go to count+1, or to 0 when count==MODULUS-1; with tick_in=0 count holds.
REQ-016 DOWN with tick_in=1: count SHALL go to count-1, or to MODULUS-1 when count==0; with tick_in=0 count holds.
REQ-017 tick_out SHALL be 1 exactly when (mode==UP, tick_in=1, count==MODULUS-1) or (mode==DOWN, tick_in=1, count==0); otherwise 0, in the same cycle, with no register.
REQ-018 LOAD with load_val<MODULUS: count SHALL take load_val on the next edge and load_err SHALL clear; tick_in is ignored.
REQ-019 LOAD with load_val>=MODULUS: count SHALL hold and load_err SHALL set.
REQ-020 load_err SHALL be sticky until the next CLEAR or the next valid LOAD.
REQ-021 lap_req=1 at an edge SHALL latch the pre-update count into lap_val and set lap_valid=1 for exactly one cycle after that edge.
REQ-022 lap_req held high SHALL capture on every edge, with lap_valid high each following cycle.
REQ-023 lap_req coincident with CLEAR or LOAD SHALL capture the value before the clear or load.
REQ-024 Next-state arithmetic SHALL be done at WIDTH+1 bits, so MODULUS=2**WIDTH wraps correctly with no overflow aliasing.
REQ-025 Latency: count and lap_val change one edge after the qualifying inputs; tick_out has zero latency.

Reset
REQ-026 rst=1 at an edge SHALL force count=0, lap_val=0, lap_valid=0 and load_err=0, overriding mode, tick_in and lap_req.
REQ-027 tick_out SHALL be 0 while rst=1.
REQ-028 Reset mid-count (e.g. count=37 in UP) SHALL give count=0 one edge later; counting resumes on the first edge after rst falls.
REQ-029 Elaboration SHALL fail if MODULUS<2 or 2**WIDTH<MODULUS.

Structure
REQ-030 Mode encodings and the default MODULUS/WIDTH constants SHALL live in a shared package (timer_pkg) used by all timer blocks.
REQ-031 The lap snapshot (lap_val, lap_valid) SHALL be a separate sub-module, lap_register, parametrised by WIDTH.
REQ-032 Cascading SHALL be done by wiring tick_out of one instance to tick_in of the next (for example MODULUS=60 seconds into MODULUS=60 minutes into MODULUS=24 hours); no global enable is added.

Verification
REQ-033 MODULUS=60, UP, tick_in=1 for 60 cycles from 0 -> count runs 0..59 then 0; tick_out=1 only in the cycle where count==59.
REQ-034 DOWN from 0 with tick_in=1 -> tick_out=1 while count==0, then count=59, then 58; tick_in=0 -> count holds.
REQ-035 LOAD load_val=45 -> count=45, load_err=0; then LOAD load_val=60 -> count stays 45, load_err=1; then CLEAR -> count=0, load_err=0.
REQ-036 UP at count=23 with lap_req=1 and tick_in=1 -> count=24 and lap_val=23; lap_valid=1 for one cycle only.
REQ-037 rst=1 during UP at count=37 with lap_req=1 -> count=0, lap_val=0, lap_valid=0, tick_out=0.
REQ-038 MODULUS=64, WIDTH=6, UP from 63 with tick_in=1 -> count=0 and tick_out=1; two cascaded 60/60 instances reach 59:59 then roll over to 00:00.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timer blocks: mode encodings, default sizing
// and the raw-mode decode that folds the unused encodings onto HOLD.
package timer_pkg;

  typedef enum logic [2:0] {
    MODE_CLEAR = 3'b000,
    MODE_HOLD  = 3'b001,
    MODE_UP    = 3'b010,
    MODE_DOWN  = 3'b011,
    MODE_LOAD  = 3'b100
  } timer_mode_e;

  localparam int TIMER_MODULUS_DEFAULT = 60;
  localparam int TIMER_WIDTH_DEFAULT   = 6;

  // Encodings 101..111 are reserved and behave as HOLD.
  function automatic timer_mode_e decode_mode(input logic [2:0] raw);
    timer_mode_e m;
    case (raw)
      3'b000:  m = MODE_CLEAR;
      3'b010:  m = MODE_UP;
      3'b011:  m = MODE_DOWN;
      3'b100:  m = MODE_LOAD;
      default: m = MODE_HOLD;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lap_register.sv
// Lap snapshot: captures the pre-update count on every edge where lap_req
// is high and raises lap_valid for the single cycle after that edge.
module lap_register #(
  parameter int WIDTH = timer_pkg::TIMER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lap_req,
  input  logic [WIDTH-1:0] cur_val,
  output logic [WIDTH-1:0] lap_val,
  output logic             lap_valid
);

  // Snapshot register and its one-cycle strobe; reset clears both.
  always_ff @(posedge clk) begin
    if (rst) begin
      lap_val   <= '0;
      lap_valid <= 1'b0;
    end else begin
      lap_valid <= lap_req;
      if (lap_req) lap_val <= cur_val;
    end
  end

endmodule

// File: rtl/time_unit_counter.sv
// Modulo-N up/down time-unit counter with load, clear, lap snapshot and a
// combinational carry/borrow for cascading (seconds -> minutes -> hours).
module time_unit_counter
  import timer_pkg::*;
#(
  parameter int MODULUS = TIMER_MODULUS_DEFAULT,
  parameter int WIDTH   = TIMER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic             tick_in,
  input  logic [WIDTH-1:0] load_val,
  input  logic             lap_req,
  output logic [WIDTH-1:0] count,
  output logic             tick_out,
  output logic [WIDTH-1:0] lap_val,
  output logic             lap_valid,
  output logic             load_err
);

  // Reject sizings where the count range cannot be represented.
  if (MODULUS < 2 || (longint'(1) << WIDTH) < longint'(MODULUS)) begin : g_bad_params
    $error("time_unit_counter: need MODULUS >= 2 and 2**WIDTH >= MODULUS");
  end

  // One extra bit so MODULUS == 2**WIDTH is representable and compares
  // never alias across the wrap point.
  localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MODULUS - 1);

  timer_mode_e      mode_d;
  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   load_ext;
  logic             at_max;
  logic             at_zero;
  logic             load_ok;
  logic [WIDTH:0]   cnt_nxt;
  logic             err_nxt;

  assign mode_d   = decode_mode(mode);
  assign cnt_ext  = {1'b0, count};
  assign load_ext = {1'b0, load_val};
  assign at_max   = (cnt_ext == MAX_EXT);
  assign at_zero  = (cnt_ext == '0);
  assign load_ok  = (load_ext < MOD_EXT);

  // Carry/borrow to the next stage; forced low during reset.
  always_comb begin
    tick_out = 1'b0;
    if (!rst && tick_in) begin
      if (mode_d == MODE_UP   && at_max)  tick_out = 1'b1;
      if (mode_d == MODE_DOWN && at_zero) tick_out = 1'b1;
    end
  end

  // Next count and load-error state from the decoded mode.
  always_comb begin
    cnt_nxt = cnt_ext;
    err_nxt = load_err;
    case (mode_d)
      MODE_CLEAR: begin
        cnt_nxt = '0;
        err_nxt = 1'b0;
      end
      MODE_UP: begin
        if (tick_in) cnt_nxt = at_max ? '0 : cnt_ext + 1'b1;
      end
      MODE_DOWN: begin
        if (tick_in) cnt_nxt = at_zero ? MAX_EXT : cnt_ext - 1'b1;
      end
      MODE_LOAD: begin
        if (load_ok) begin
          cnt_nxt = load_ext;
          err_nxt = 1'b0;
        end else begin
          err_nxt = 1'b1;
        end
      end
      default: begin
        cnt_nxt = cnt_ext;
        err_nxt = load_err;
      end
    endcase
  end

  // Count and sticky load-error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      load_err <= 1'b0;
    end else begin
      count    <= WIDTH'(cnt_nxt);
      load_err <= err_nxt;
    end
  end

  lap_register #(
    .WIDTH(WIDTH)
  ) u_lap (
    .clk      (clk),
    .rst      (rst),
    .lap_req  (lap_req),
    .cur_val  (count),
    .lap_val  (lap_val),
    .lap_valid(lap_valid)
  );

endmodule
